// File: rtl/j_zdet_pipe.sv
// Burst zero / all-ones detector: 2-cycle pipeline from last-word accept to out_valid.
// The whole pipeline stalls together while a result is waiting for out_ready.
module j_zdet_pipe #(
    parameter int WIDTH = 32,
    parameter int GROUP = 4,
    parameter int IDXW  = 5,
    parameter int CNTW  = 8
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_zero,
    output logic [IDXW-1:0]  out_idx,
    output logic [CNTW-1:0]  out_word
);
    localparam int NGRP = WIDTH / GROUP;
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic             advance;
    logic             accept;
    logic             mode_eff;
    logic [WIDTH-1:0] chk_word;

    logic             first_q, first_d;
    logic             mode_q, mode_d;
    logic             s1_vld_q, s1_vld_d;
    logic             s1_last_q, s1_last_d;
    logic [NGRP-1:0]  s1_grp_q, s1_grp_d;
    logic [IDXW-1:0]  s1_idx_q, s1_idx_d;

    logic             s2_vld_q, s2_vld_d;
    logic             s2_last_q, s2_last_d;
    logic             acc_match_q, acc_match_d;
    logic [IDXW-1:0]  acc_idx_q, acc_idx_d;
    logic [CNTW-1:0]  acc_word_q, acc_word_d;
    logic [CNTW-1:0]  acc_cnt_q, acc_cnt_d;

    logic             base_clr;
    logic             base_match;
    logic [IDXW-1:0]  base_idx;
    logic [CNTW-1:0]  base_word;
    logic [CNTW-1:0]  base_cnt;
    logic             word_match;

    logic             out_valid_q, out_valid_d;
    logic             out_zero_q, out_zero_d;
    logic [IDXW-1:0]  out_idx_q, out_idx_d;
    logic [CNTW-1:0]  out_word_q, out_word_d;

    assign advance  = ~out_valid_q | out_ready;
    assign in_ready = advance & ~reset;
    assign accept   = in_valid & in_ready;

    // Stage 1: mode is latched on a burst's first word and reused after that.
    always_comb begin
        mode_eff  = first_q ? mode : mode_q;
        chk_word  = mode_eff ? ~in_data : in_data;
        first_d   = first_q;
        mode_d    = mode_q;
        s1_vld_d  = s1_vld_q;
        s1_last_d = s1_last_q;
        s1_grp_d  = s1_grp_q;
        s1_idx_d  = s1_idx_q;
        if (accept) begin
            first_d = in_last;
            mode_d  = mode_eff;
        end
        if (advance) begin
            s1_vld_d  = accept;
            s1_last_d = in_last;
            for (int g = 0; g < NGRP; g++) begin
                s1_grp_d[g] = ~|chk_word[g*GROUP +: GROUP];
            end
            s1_idx_d = '0;
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (chk_word[i]) s1_idx_d = IDXW'(i);
            end
        end
    end

    // Stage 2: a burst that just finished in stage 2 starts the next from a clean accumulator.
    always_comb begin
        base_clr    = s2_vld_q & s2_last_q;
        base_match  = base_clr ? 1'b1 : acc_match_q;
        base_idx    = base_clr ? '0 : acc_idx_q;
        base_word   = base_clr ? '0 : acc_word_q;
        base_cnt    = base_clr ? '0 : acc_cnt_q;
        word_match  = &s1_grp_q;
        s2_vld_d    = s2_vld_q;
        s2_last_d   = s2_last_q;
        acc_match_d = acc_match_q;
        acc_idx_d   = acc_idx_q;
        acc_word_d  = acc_word_q;
        acc_cnt_d   = acc_cnt_q;
        if (advance) begin
            s2_vld_d    = s1_vld_q;
            s2_last_d   = s1_last_q;
            acc_match_d = base_match;
            acc_idx_d   = base_idx;
            acc_word_d  = base_word;
            acc_cnt_d   = base_cnt;
            if (s1_vld_q) begin
                acc_match_d = base_match & word_match;
                if (base_match & ~word_match) begin
                    acc_idx_d  = s1_idx_q;
                    acc_word_d = base_cnt;
                end
                acc_cnt_d = (base_cnt == CNT_MAX) ? CNT_MAX : base_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_zero_d  = out_zero_q;
        out_idx_d   = out_idx_q;
        out_word_d  = out_word_q;
        if (advance) begin
            out_valid_d = s2_vld_q & s2_last_q;
            if (s2_vld_q & s2_last_q) begin
                out_zero_d = acc_match_q;
                out_idx_d  = acc_match_q ? '0 : acc_idx_q;
                out_word_d = acc_match_q ? '0 : acc_word_q;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            first_q     <= 1'b1;
            mode_q      <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_grp_q    <= '0;
            s1_idx_q    <= '0;
            s2_vld_q    <= 1'b0;
            s2_last_q   <= 1'b0;
            acc_match_q <= 1'b1;
            acc_idx_q   <= '0;
            acc_word_q  <= '0;
            acc_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_zero_q  <= 1'b0;
            out_idx_q   <= '0;
            out_word_q  <= '0;
        end else begin
            first_q     <= first_d;
            mode_q      <= mode_d;
            s1_vld_q    <= s1_vld_d;
            s1_last_q   <= s1_last_d;
            s1_grp_q    <= s1_grp_d;
            s1_idx_q    <= s1_idx_d;
            s2_vld_q    <= s2_vld_d;
            s2_last_q   <= s2_last_d;
            acc_match_q <= acc_match_d;
            acc_idx_q   <= acc_idx_d;
            acc_word_q  <= acc_word_d;
            acc_cnt_q   <= acc_cnt_d;
            out_valid_q <= out_valid_d;
            out_zero_q  <= out_zero_d;
            out_idx_q   <= out_idx_d;
            out_word_q  <= out_word_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_zero  = out_zero_q;
    assign out_idx   = out_idx_q;
    assign out_word  = out_word_q;

endmodule

// File: tb/tb_j_zdet_pipe.sv
// Directed bench for j_zdet_pipe; a second instance with a 4-bit word counter covers saturation.
module tb_j_zdet_pipe;
    logic        sys_clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        mode;
    logic        out_ready;

    logic        in_ready, out_valid, out_zero;
    logic [4:0]  out_idx;
    logic [7:0]  out_word;
    logic        in_ready4, out_valid4, out_zero4;
    logic [4:0]  out_idx4;
    logic [3:0]  out_word4;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 sys_clk = ~sys_clk;

    j_zdet_pipe #(.WIDTH(32), .GROUP(4), .IDXW(5), .CNTW(8)) dut (
        .sys_clk(sys_clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_zero(out_zero), .out_idx(out_idx), .out_word(out_word)
    );

    j_zdet_pipe #(.WIDTH(32), .GROUP(4), .IDXW(5), .CNTW(4)) dut4 (
        .sys_clk(sys_clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_last(in_last), .mode(mode), .out_valid(out_valid4),
        .out_ready(out_ready), .out_zero(out_zero4), .out_idx(out_idx4), .out_word(out_word4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l, input logic m);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        mode     = m;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("send_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait2(input string tag);
        tick();
        chk({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_lat2_valid"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        mode      = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_zero",  32'(out_zero),  32'd0);
        chk("rst_out_idx",   32'(out_idx),   32'd0);
        chk("rst_out_word",  32'(out_word),  32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // single all-zero word
        send(32'h0000_0000, 1'b1, 1'b0);
        wait2("t1");
        chk("t1_zero", 32'(out_zero), 32'd1);
        chk("t1_idx",  32'(out_idx),  32'd0);
        chk("t1_word", 32'(out_word), 32'd0);
        tick();
        chk("t1_valid_clear", 32'(out_valid), 32'd0);

        // first mismatch in word 2, later mismatch ignored
        send(32'h0000_0000, 1'b0, 1'b0);
        send(32'h0000_0000, 1'b0, 1'b0);
        send(32'h0010_0000, 1'b0, 1'b0);
        send(32'h0000_0001, 1'b1, 1'b0);
        wait2("t2");
        chk("t2_zero", 32'(out_zero), 32'd0);
        chk("t2_idx",  32'(out_idx),  32'd20);
        chk("t2_word", 32'(out_word), 32'd2);

        // mode sampled on first word only
        send(32'hFFFF_FFFF, 1'b0, 1'b1);
        send(32'hFFFF_FF7F, 1'b1, 1'b0);
        wait2("t3");
        chk("t3_zero", 32'(out_zero), 32'd0);
        chk("t3_idx",  32'(out_idx),  32'd7);
        chk("t3_word", 32'(out_word), 32'd1);

        send(32'hFFFF_FFFF, 1'b1, 1'b1);
        wait2("t4");
        chk("t4_zero", 32'(out_zero), 32'd1);
        chk("t4_idx",  32'(out_idx),  32'd0);

        // back-to-back single-word bursts
        send(32'h0000_0000, 1'b1, 1'b0);
        send(32'h0000_0004, 1'b1, 1'b0);
        tick();
        chk("t5a_valid", 32'(out_valid), 32'd1);
        chk("t5a_zero",  32'(out_zero),  32'd1);
        tick();
        chk("t5b_valid", 32'(out_valid), 32'd1);
        chk("t5b_zero",  32'(out_zero),  32'd0);
        chk("t5b_idx",   32'(out_idx),   32'd2);
        chk("t5b_word",  32'(out_word),  32'd0);
        tick();
        chk("t5_valid_clear", 32'(out_valid), 32'd0);

        // stall with three bursts in flight
        out_ready = 1'b0;
        send(32'h0000_0100, 1'b1, 1'b0);
        send(32'h0000_0010, 1'b1, 1'b0);
        send(32'h0000_0000, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("t6_hold_valid", 32'(out_valid), 32'd1);
            chk("t6_hold_idx",   32'(out_idx),   32'd8);
            chk("t6_hold_zero",  32'(out_zero),  32'd0);
            chk("t6_in_ready",   32'(in_ready),  32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("t6_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("t6_b_valid", 32'(out_valid), 32'd1);
        chk("t6_b_idx",   32'(out_idx),   32'd4);
        chk("t6_b_zero",  32'(out_zero),  32'd0);
        tick();
        chk("t6_c_valid", 32'(out_valid), 32'd1);
        chk("t6_c_zero",  32'(out_zero),  32'd1);
        chk("t6_c_idx",   32'(out_idx),   32'd0);
        tick();
        chk("t6_no_extra_1", 32'(out_valid), 32'd0);
        tick();
        chk("t6_no_extra_2", 32'(out_valid), 32'd0);

        // counter saturation: 20 zero words then a mismatch at word 20
        for (int k = 0; k < 20; k++) send(32'h0000_0000, 1'b0, 1'b0);
        send(32'h0000_0002, 1'b1, 1'b0);
        wait2("t7");
        chk("t7_c4_valid", 32'(out_valid4), 32'd1);
        chk("t7_c4_zero",  32'(out_zero4),  32'd0);
        chk("t7_c4_idx",   32'(out_idx4),   32'd1);
        chk("t7_c4_word",  32'(out_word4),  32'd15);
        chk("t7_c8_idx",   32'(out_idx),    32'd1);
        chk("t7_c8_word",  32'(out_word),   32'd20);

        // reset mid-burst discards partial burst
        send(32'h0000_0001, 1'b0, 1'b0);
        send(32'h0000_0000, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("t8_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("t8_post_rst_valid", 32'(out_valid), 32'd0);
        send(32'h8000_0000, 1'b1, 1'b0);
        wait2("t8");
        chk("t8_zero", 32'(out_zero), 32'd0);
        chk("t8_idx",  32'(out_idx),  32'd31);
        chk("t8_word", 32'(out_word), 32'd0);
        tick();
        chk("t8_single_1", 32'(out_valid), 32'd0);
        tick();
        chk("t8_single_2", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
